// File: rtl/rule_set_intersect.sv
// Two-pointer merge of two sorted, right-aligned rule ID sets.
// Emits the intersection in the same packed format plus count and lowest common ID.
module rule_set_intersect #(
  parameter int NUM_RULE_ID   = 8,
  parameter int RULE_ID_WIDTH = 3,
  localparam int SLOT_W = 1 + RULE_ID_WIDTH,
  localparam int SET_W  = NUM_RULE_ID * SLOT_W,
  localparam int PTR_W  = $clog2(NUM_RULE_ID + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:SET_W-1]         set_a,
  input  logic [0:SET_W-1]         set_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:SET_W-1]         out_set,
  output logic                     out_match,
  output logic [RULE_ID_WIDTH-1:0] out_best_id,
  output logic [PTR_W-1:0]         out_count
);

  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

  state_t                                    state_q, state_d;
  logic [0:SET_W-1]                          a_q, a_d, b_q, b_d;
  logic [PTR_W-1:0]                          ia_q, ia_d, ib_q, ib_d, wr_q, wr_d;
  logic [NUM_RULE_ID-1:0][RULE_ID_WIDTH-1:0] res_q, res_d;
  logic                                      out_valid_q, out_valid_d;
  logic [0:SET_W-1]                          out_set_q, out_set_d;
  logic                                      out_match_q, out_match_d;
  logic [RULE_ID_WIDTH-1:0]                  out_best_id_q, out_best_id_d;
  logic [PTR_W-1:0]                          out_count_q, out_count_d;

  logic [SLOT_W-1:0] slot_a, slot_b;
  logic [0:SET_W-1]  res_left;

  function automatic logic any_valid(input logic [0:SET_W-1] s);
    logic v;
    v = 1'b0;
    for (int k = 0; k < NUM_RULE_ID; k++) v = v | s[k*SLOT_W];
    return v;
  endfunction

  function automatic logic [SLOT_W-1:0] slot_at(input logic [0:SET_W-1] s,
                                                input logic [PTR_W-1:0] idx);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_RULE_ID; k++)
      if (idx == PTR_W'(k)) r = s[k*SLOT_W +: SLOT_W];
    return r;
  endfunction

  // Results are packed from slot 0 upward, then shifted down to end at the last slot.
  always_comb begin
    res_left = '0;
    for (int j = 0; j < NUM_RULE_ID; j++)
      if (PTR_W'(j) < wr_q) res_left[j*SLOT_W +: SLOT_W] = {1'b1, res_q[j]};
  end

  assign slot_a = slot_at(a_q, ia_q);
  assign slot_b = slot_at(b_q, ib_q);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    ia_d          = ia_q;
    ib_d          = ib_q;
    wr_d          = wr_q;
    res_d         = res_q;
    out_valid_d   = out_valid_q;
    out_set_d     = out_set_q;
    out_match_d   = out_match_q;
    out_best_id_d = out_best_id_q;
    out_count_d   = out_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = set_a;
          b_d   = set_b;
          ia_d  = '0;
          ib_d  = '0;
          wr_d  = '0;
          res_d = '0;
          if (!any_valid(set_a) || !any_valid(set_b)) begin
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_set_d     = '0;
            out_match_d   = 1'b0;
            out_best_id_d = '0;
            out_count_d   = '0;
          end else begin
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        if (ia_q == PTR_W'(NUM_RULE_ID) || ib_q == PTR_W'(NUM_RULE_ID)) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_set_d     = res_left >> (SLOT_W * (NUM_RULE_ID - int'(wr_q)));
          out_match_d   = (wr_q != '0);
          out_best_id_d = (wr_q != '0) ? res_q[0] : '0;
          out_count_d   = wr_q;
        end else if (!slot_a[SLOT_W-1] || !slot_b[SLOT_W-1]) begin
          if (!slot_a[SLOT_W-1]) ia_d = ia_q + 1'b1;
          if (!slot_b[SLOT_W-1]) ib_d = ib_q + 1'b1;
        end else if (slot_a[RULE_ID_WIDTH-1:0] == slot_b[RULE_ID_WIDTH-1:0]) begin
          // wr never exceeds min(ia, ib), so it is always below NUM_RULE_ID here
          for (int k = 0; k < NUM_RULE_ID; k++)
            if (wr_q == PTR_W'(k)) res_d[k] = slot_a[RULE_ID_WIDTH-1:0];
          wr_d = wr_q + 1'b1;
          ia_d = ia_q + 1'b1;
          ib_d = ib_q + 1'b1;
        end else if (slot_a[RULE_ID_WIDTH-1:0] < slot_b[RULE_ID_WIDTH-1:0]) begin
          ia_d = ia_q + 1'b1;
        end else begin
          ib_d = ib_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      ia_q          <= '0;
      ib_q          <= '0;
      wr_q          <= '0;
      res_q         <= '0;
      out_valid_q   <= 1'b0;
      out_set_q     <= '0;
      out_match_q   <= 1'b0;
      out_best_id_q <= '0;
      out_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      ia_q          <= ia_d;
      ib_q          <= ib_d;
      wr_q          <= wr_d;
      res_q         <= res_d;
      out_valid_q   <= out_valid_d;
      out_set_q     <= out_set_d;
      out_match_q   <= out_match_d;
      out_best_id_q <= out_best_id_d;
      out_count_q   <= out_count_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_set     = out_set_q;
  assign out_match   = out_match_q;
  assign out_best_id = out_best_id_q;
  assign out_count   = out_count_q;

endmodule

// File: tb/tb_rule_set_intersect.sv
// Directed vector bench for rule_set_intersect: table of set pairs plus
// backpressure and mid-merge reset sequences.
module tb_rule_set_intersect;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] set_a, set_b;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_set;
  logic        out_match;
  logic [2:0]  out_best_id;
  logic [3:0]  out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rule_set_intersect dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .set_a(set_a), .set_b(set_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_set(out_set), .out_match(out_match),
    .out_best_id(out_best_id), .out_count(out_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_set;
    logic [3:0]  exp_cnt;
    logic        exp_match;
    logic [2:0]  exp_best;
    int          exact_lat;  // 0: only the 18-cycle bound applies
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a pair, return cycles from accept edge until out_valid is seen.
  task automatic txn(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    set_a = a;
    set_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (v.exact_lat != 0) chk({tag, "_latency"}, 32'(lat), 32'(v.exact_lat));
    else                  chk({tag, "_latency_le18"}, 32'(lat <= 18), 32'd1);
    chk({tag, "_out_set"}, out_set, v.exp_set);
    chk({tag, "_out_count"}, 32'(out_count), 32'(v.exp_cnt));
    chk({tag, "_out_match"}, 32'(out_match), 32'(v.exp_match));
    chk({tag, "_out_best_id"}, 32'(out_best_id), 32'(v.exp_best));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h0000_8AEF, 32'h0000_0AEF, 32'h0000_0AEF, 4'd3, 1'b1, 3'd2, 0};
    vecs[1] = '{32'h0000_9AEF, 32'h0000_BDEF, 32'h0000_00EF, 4'd2, 1'b1, 3'd6, 0};
    vecs[2] = '{32'h0000_0000, 32'h0000_000F, 32'h0000_0000, 4'd0, 1'b0, 3'd0, 1};
    vecs[3] = '{32'h0000_0008, 32'h0000_000F, 32'h0000_0000, 4'd0, 1'b0, 3'd0, 0};
    vecs[4] = '{32'h89AB_CDEF, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'd8, 1'b1, 3'd0, 0};
    vecs[5] = '{32'h89AB_CDEF, 32'h0000_000F, 32'h0000_000F, 4'd1, 1'b1, 3'd7, 0};
    vecs[6] = '{32'h0000_0AEF, 32'h0000_0000, 32'h0000_0000, 4'd0, 1'b0, 3'd0, 1};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_a = '0;
    set_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_set", out_set, 32'd0);
    chk("reset_out_match", 32'(out_match), 32'd0);
    chk("reset_out_best_id", 32'(out_best_id), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].a, vecs[i].b, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and new pairs must be ignored
    txn(vecs[0].a, vecs[0].b, lat);
    check_result("bp", vecs[0], lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      set_a = 32'h89AB_CDEF;
      set_b = 32'h89AB_CDEF;
      in_valid = c[0];
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_out_set_held", out_set, 32'h0000_0AEF);
      chk("bp_out_count_held", 32'(out_count), 32'd3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("bp");
    chk("bp_set_retained", out_set, 32'h0000_0AEF);
    txn(vecs[1].a, vecs[1].b, lat);
    check_result("bp_next", vecs[1], lat);
    release_result("bp_next");

    // Reset while merging discards the transaction
    @(negedge clk);
    set_a = 32'h89AB_CDEF;
    set_b = 32'h89AB_CDEF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_merge", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_set", out_set, 32'd0);
    chk("mid_rst_out_match", 32'(out_match), 32'd0);
    chk("mid_rst_out_best_id", 32'(out_best_id), 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    chk("mid_rst_stays_idle", 32'(out_valid), 32'd0);
    txn(vecs[0].a, vecs[0].b, lat);
    check_result("post_rst", vecs[0], lat);
    release_result("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
